multiplicador_n: RTL and testbench

Parametrised sequential multiplier computing the product of NUM_OPS operands of WIDTH bits each into an OUT_WIDTH result, with signed/unsigned mode and overflow detection. It replaces the fixed three-operand 32-bit multiplier in the arithmetic datapath. It keeps the same valid_data / Done_Flag / ack handshake, so existing testers drive it unchanged. Computation is shift-add, one multiplier bit per cycle, with deterministic latency.

---
 rtl/multiplicador_n.sv | 200 ++++++++++++++++++++
 tb/tb_multiplicador_n.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/multiplicador_n.sv
// multiplicador_n: sequential shift-add multiplier of NUM_OPS operands of
// WIDTH bits each into an OUT_WIDTH result.
// Supports unsigned or two's-complement mode and flags overflow on the
// exact product. Uses a valid_data / Done_Flag / ack handshake.
module multiplicador_n #(
  parameter int WIDTH     = 32,
  parameter int NUM_OPS   = 3,
  parameter int OUT_WIDTH = 64,
  parameter int SIGNED    = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_OPS*WIDTH-1:0]   operandos,
  input  logic                       valid_data,
  input  logic                       ack,
  output logic [OUT_WIDTH-1:0]       producto,
  output logic                       Done_Flag,
  output logic                       overflow,
  output logic                       busy
);

  localparam int PW = OUT_WIDTH + WIDTH;
  localparam int OW = NUM_OPS * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam int KW = $clog2(NUM_OPS);
  localparam logic [CW-1:0] LAST_BIT   = CW'(WIDTH - 1);
  localparam logic [KW-1:0] FIRST_LEFT = KW'(NUM_OPS - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state_q, state_d;

  // capture stage
  logic                 neg_p0;
  logic                 zero_p0;
  // accumulate stage
  logic [OUT_WIDTH-1:0] acc_p1;
  logic [PW-1:0]        part_p1;
  logic [WIDTH-1:0]     mul_p1;
  logic [OW-1:0]        rest_p1;
  logic                 big_p1;
  logic [CW-1:0]        bit_cnt_p1;
  logic [KW-1:0]        ops_left_p1;
  logic                 fin_p1;
  // result stage
  logic [OUT_WIDTH-1:0] prod_p2;
  logic                 ovf_p2;

  logic [OW-1:0]        mags_c;
  logic                 neg_c;
  logic                 zero_c;
  logic [PW-1:0]        part_next_c;

  // Magnitude of an operand; the most negative value maps to 2^(WIDTH-1),
  // which still fits in WIDTH unsigned bits.
  function automatic logic [WIDTH-1:0] mag_of(input logic signed [WIDTH-1:0] v);
    if ((SIGNED != 0) && v[WIDTH-1])
      mag_of = -v;
    else
      mag_of = v;
  endfunction

  // Re-apply the product sign to the magnitude, modulo 2^OUT_WIDTH.
  function automatic logic [OUT_WIDTH-1:0] apply_sign(input logic [OUT_WIDTH-1:0] m,
                                                      input logic neg);
    apply_sign = neg ? -m : m;
  endfunction

  // Overflow from the low magnitude bits plus the sticky "magnitude >= 2^OUT_WIDTH".
  function automatic logic ovf_of(input logic [OUT_WIDTH-1:0] m, input logic big,
                                  input logic neg);
    if (SIGNED == 0)
      ovf_of = big;
    else if (neg)
      ovf_of = big | (m[OUT_WIDTH-1] & (|m[OUT_WIDTH-2:0]));
    else
      ovf_of = big | m[OUT_WIDTH-1];
  endfunction

  // Operand magnitudes, result sign and zero detection from the raw inputs.
  always_comb begin
    mags_c = '0;
    neg_c  = 1'b0;
    zero_c = 1'b0;
    for (int i = 0; i < NUM_OPS; i++) begin
      mags_c[i*WIDTH +: WIDTH] = mag_of(operandos[i*WIDTH +: WIDTH]);
      if (SIGNED != 0)
        neg_c = neg_c ^ operandos[i*WIDTH + WIDTH - 1];
      zero_c = zero_c | (operandos[i*WIDTH +: WIDTH] == '0);
    end
  end

  // MSB-first shift-add step: partial = 2*partial + bit*accumulator.
  always_comb begin
    part_next_c = {part_p1[PW-2:0], 1'b0};
    if (mul_p1[WIDTH-1])
      part_next_c = part_next_c + PW'(acc_p1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic and status outputs decoded from the state register.
  always_comb begin
    state_d   = state_q;
    Done_Flag = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_data)
          state_d = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (fin_p1)
          state_d = DONE;
      end
      DONE: begin
        Done_Flag = 1'b1;
        if (ack)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture in IDLE, one multiplier bit per CALC cycle, then a
  // final cycle that applies the sign and resolves overflow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      neg_p0      <= 1'b0;
      zero_p0     <= 1'b0;
      acc_p1      <= '0;
      part_p1     <= '0;
      mul_p1      <= '0;
      rest_p1     <= '0;
      big_p1      <= 1'b0;
      bit_cnt_p1  <= '0;
      ops_left_p1 <= '0;
      fin_p1      <= 1'b0;
      prod_p2     <= '0;
      ovf_p2      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_data) begin
            neg_p0      <= neg_c;
            zero_p0     <= zero_c;
            acc_p1      <= OUT_WIDTH'(mags_c[WIDTH-1:0]);
            mul_p1      <= mags_c[2*WIDTH-1 -: WIDTH];
            rest_p1     <= mags_c >> (2 * WIDTH);
            part_p1     <= '0;
            big_p1      <= 1'b0;
            bit_cnt_p1  <= '0;
            ops_left_p1 <= FIRST_LEFT;
            fin_p1      <= 1'b0;
          end
        end
        CALC: begin
          if (fin_p1) begin
            fin_p1 <= 1'b0;
            if (zero_p0) begin
              prod_p2 <= '0;
              ovf_p2  <= 1'b0;
            end else begin
              prod_p2 <= apply_sign(acc_p1, neg_p0);
              ovf_p2  <= ovf_of(acc_p1, big_p1, neg_p0);
            end
          end else if (bit_cnt_p1 == LAST_BIT) begin
            // Operand finished: fold the full partial product back into the
            // accumulator, remembering any bits above OUT_WIDTH.
            acc_p1      <= part_next_c[OUT_WIDTH-1:0];
            big_p1      <= big_p1 | (|part_next_c[PW-1:OUT_WIDTH]);
            part_p1     <= '0;
            bit_cnt_p1  <= '0;
            mul_p1      <= rest_p1[WIDTH-1:0];
            rest_p1     <= rest_p1 >> WIDTH;
            ops_left_p1 <= ops_left_p1 - KW'(1);
            if (ops_left_p1 == KW'(1))
              fin_p1 <= 1'b1;
          end else begin
            part_p1    <= part_next_c;
            mul_p1     <= mul_p1 << 1;
            bit_cnt_p1 <= bit_cnt_p1 + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign producto = prod_p2;
  assign overflow = ovf_p2;

endmodule

// File: tb/tb_multiplicador_n.sv
// Directed testbench for multiplicador_n: default unsigned, signed, and
// 8-bit/4-operand configurations run side by side.
module tb_multiplicador_n;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid = 1'b0;
  logic        ack_tie = 1'b1;
  logic        ack_man = 1'b0;

  logic [95:0] ops_d = '0;
  logic [95:0] ops_s = '0;
  logic [31:0] ops_8 = '0;
  logic        ack_d, ack_s, ack_8;
  logic [63:0] prod_d, prod_s;
  logic [15:0] prod_8;
  logic        done_d, done_s, done_8;
  logic        ovf_d, ovf_s, ovf_8;
  logic        busy_d, busy_s, busy_8;

  int          n_checks = 0;
  int          n_fail = 0;

  int          lat_d, lat_s, lat_8;
  logic [63:0] p_d, p_s;
  logic [15:0] p_8;
  logic        o_d, o_s, o_8, b_d, gone_d;

  always #5 clk = ~clk;

  assign ack_d = ack_tie ? done_d : ack_man;
  assign ack_s = ack_tie ? done_s : ack_man;
  assign ack_8 = ack_tie ? done_8 : ack_man;

  multiplicador_n u_dut_d (
    .clk(clk), .reset(reset), .operandos(ops_d), .valid_data(valid), .ack(ack_d),
    .producto(prod_d), .Done_Flag(done_d), .overflow(ovf_d), .busy(busy_d)
  );

  multiplicador_n #(.SIGNED(1)) u_dut_s (
    .clk(clk), .reset(reset), .operandos(ops_s), .valid_data(valid), .ack(ack_s),
    .producto(prod_s), .Done_Flag(done_s), .overflow(ovf_s), .busy(busy_s)
  );

  multiplicador_n #(.WIDTH(8), .NUM_OPS(4), .OUT_WIDTH(16)) u_dut_8 (
    .clk(clk), .reset(reset), .operandos(ops_8), .valid_data(valid), .ack(ack_8),
    .producto(prod_8), .Done_Flag(done_8), .overflow(ovf_8), .busy(busy_8)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One request to all three instances; records latency (edges after the
  // capture edge) and the outputs seen while Done_Flag is high.
  task automatic run_all();
    lat_d = -1; lat_s = -1; lat_8 = -1;
    p_d = '0; p_s = '0; p_8 = '0;
    o_d = 1'b0; o_s = 1'b0; o_8 = 1'b0;
    gone_d = 1'b0;
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    b_d = busy_d;
    for (int c = 1; c <= 70; c++) begin
      @(posedge clk); #1;
      if (lat_d > 0 && c == lat_d + 1) gone_d = !done_d;
      if (done_d && lat_d < 0) begin lat_d = c; p_d = prod_d; o_d = ovf_d; end
      if (done_s && lat_s < 0) begin lat_s = c; p_s = prod_s; o_s = ovf_s; end
      if (done_8 && lat_8 < 0) begin lat_8 = c; p_8 = prod_8; o_8 = ovf_8; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   cyc;
    logic stable;
    logic saw;

    // Reset state
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_prod", prod_d, 64'd0);
    check_eq("rst_done", done_d, 1'b0);
    check_eq("rst_ovf", ovf_d, 1'b0);
    check_eq("rst_busy", busy_d, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;

    // 4*3*2 unsigned; -4*3*2 signed; 2*3*4*5 on the 8-bit instance
    ops_d = {32'd2, 32'd3, 32'd4};
    ops_s = {32'd2, 32'd3, 32'hFFFF_FFFC};
    ops_8 = {8'd5, 8'd4, 8'd3, 8'd2};
    run_all();
    check_eq("r1_busy_d", b_d, 1'b1);
    check_eq("r1_lat_d", lat_d, 65);
    check_eq("r1_prod_d", p_d, 64'd24);
    check_eq("r1_ovf_d", o_d, 1'b0);
    check_eq("r1_done_1cyc_d", gone_d, 1'b1);
    check_eq("r1_lat_s", lat_s, 65);
    check_eq("r1_prod_s", p_s, 64'hFFFF_FFFF_FFFF_FFE8);
    check_eq("r1_ovf_s", o_s, 1'b0);
    check_eq("r1_lat_8", lat_8, 25);
    check_eq("r1_prod_8", p_8, 16'd120);
    check_eq("r1_ovf_8", o_8, 1'b0);

    // Zero operands; the signed case is (-2^31)^3 = -2^93, which is 0 mod 2^64
    // but overflows; the 8-bit case overflows in intermediate stages first.
    ops_d = {32'd5, 32'd0, 32'hFFFF_FFFF};
    ops_s = {3{32'h8000_0000}};
    ops_8 = {8'd0, 8'hFF, 8'hFF, 8'hFF};
    run_all();
    check_eq("r2_prod_d", p_d, 64'd0);
    check_eq("r2_ovf_d", o_d, 1'b0);
    check_eq("r2_prod_s", p_s, 64'd0);
    check_eq("r2_ovf_s", o_s, 1'b1);
    check_eq("r2_lat_8", lat_8, 25);
    check_eq("r2_prod_8", p_8, 16'd0);
    check_eq("r2_ovf_8", o_8, 1'b0);

    // Overflow: (2^32-1)^3 mod 2^64 = 3*2^32-1; (-2^31)^2*1 = 2^62 fits;
    // 255^4 = 4228250625, mod 2^16 = 0xFC01.
    ops_d = {3{32'hFFFF_FFFF}};
    ops_s = {32'd1, 32'h8000_0000, 32'h8000_0000};
    ops_8 = {4{8'hFF}};
    run_all();
    check_eq("r3_lat_d", lat_d, 65);
    check_eq("r3_prod_d", p_d, 64'h0000_0002_FFFF_FFFF);
    check_eq("r3_ovf_d", o_d, 1'b1);
    check_eq("r3_prod_s", p_s, 64'h4000_0000_0000_0000);
    check_eq("r3_ovf_s", o_s, 1'b0);
    check_eq("r3_prod_8", p_8, 16'hFC01);
    check_eq("r3_ovf_8", o_8, 1'b1);

    // Reset 20 cycles into an operation aborts it
    ops_d = {32'd5, 32'd6, 32'd7};
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check_eq("abort_prod", prod_d, 64'd0);
    check_eq("abort_ovf", ovf_d, 1'b0);
    check_eq("abort_busy", busy_d, 1'b0);
    check_eq("abort_done", done_d, 1'b0);
    saw = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      if (done_d) saw = 1'b1;
    end
    check_eq("abort_no_done", saw, 1'b0);

    // Normal operation after the abort
    ops_d = {32'd2, 32'd3, 32'd4};
    run_all();
    check_eq("r4_lat_d", lat_d, 65);
    check_eq("r4_prod_d", p_d, 64'd24);

    // Held acknowledge with valid_data high during DONE
    ack_tie = 1'b0;
    ack_man = 1'b0;
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    cyc = 0;
    while (!done_d && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("held_lat", cyc, 65);
    ops_d = {32'd7, 32'd7, 32'd7};
    valid = 1'b1;
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (done_d !== 1'b1 || prod_d !== 64'd24 || busy_d !== 1'b0) stable = 1'b0;
    end
    check_eq("held_stable", stable, 1'b1);
    ack_man = 1'b1;
    @(posedge clk); #1;
    ack_man = 1'b0;
    valid = 1'b0;
    check_eq("held_ack_done", done_d, 1'b0);
    check_eq("held_ack_busy", busy_d, 1'b0);
    check_eq("held_ack_prod", prod_d, 64'd24);
    @(posedge clk); #1;
    check_eq("held_idle_busy", busy_d, 1'b0);
    ack_tie = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
